aes_sched: RTL and testbench

Round-robin scheduler that shares one AES core among N requesters on a single clock. It accepts {key, message, direction} jobs through per-requester valid/ready handshakes and sequences the core's chip-enable. It captures the core's `done`/result and returns the result through one response channel tagged with the requester id. It sits between the host-side job sources (SPI front end, DMA) and `aes_core`.

---
 rtl/aes_sched_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/aes_sched.sv | 146 ++++++++++++++
 tb/tb_aes_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES core scheduler.
//   state_t         : scheduler FSM states (IDLE, RUN, RESP, GAP)
//   K_*             : legal key widths
//   INV_*           : core capability encodings
//   dir_supported() : whether a job direction can be served by the core
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int unsigned K_128 = 128;
  localparam int unsigned K_192 = 192;
  localparam int unsigned K_256 = 256;

  localparam int unsigned INV_ENC_ONLY = 0;
  localparam int unsigned INV_DEC_ONLY = 1;
  localparam int unsigned INV_BOTH     = 2;

  // dir: 0 = encrypt, 1 = decrypt
  function automatic logic dir_supported(input int unsigned inv, input logic dir);
    logic ok;
    ok = 1'b0;
    if (inv == INV_BOTH)                   ok = 1'b1;
    else if (inv == INV_ENC_ONLY && !dir)  ok = 1'b1;
    else if (inv == INV_DEC_ONLY && dir)   ok = 1'b1;
    return ok;
  endfunction

  function automatic logic key_width_legal(input int unsigned k);
    return (k == K_128) || (k == K_192) || (k == K_256);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : per-requester request
//   advance    : move priority to the slot after the current winner
//   grant      : one-hot grant (combinational), zero when no request
//   idx        : encoded index of the winner
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] pos;
  logic          found;

  // Scan from the pointer upwards with wrap; first asserted request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = IW'((32'(ptr) + i) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/aes_sched.sv
// Round-robin scheduler sharing one AES core among N requesters.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester job handshake (ready is one-hot or zero)
//   req_key/msg/dir     : per-requester job payload (dir 1 = decrypt)
//   resp_*              : single response channel tagged with requester id
//   core_ce             : core enable, high for the whole conversion
//   core_key/msg/dir    : registered job driven to the core
//   core_done/core_data : core completion and result
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned K   = 128,
  parameter int unsigned INV = 2,
  parameter int unsigned N   = 4,
  parameter int unsigned TMO = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N-1:0][K-1:0]    req_key,
  input  logic [N-1:0][127:0]    req_msg,
  input  logic [N-1:0]           req_dir,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [$clog2(N)-1:0]   resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err,
  output logic                   core_ce,
  output logic [K-1:0]           core_key,
  output logic [127:0]           core_msg,
  output logic                   core_dir,
  input  logic                   core_done,
  input  logic [127:0]           core_data
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned WW = $clog2(TMO) + 1;

  if (!key_width_legal(K)) begin : g_bad_k
    $error("aes_sched: K must be 128, 192 or 256");
  end
  if (INV > INV_BOTH) begin : g_bad_inv
    $error("aes_sched: INV must be 0, 1 or 2");
  end
  if (N < 2 || N > 8) begin : g_bad_n
    $error("aes_sched: N must be in 2..8");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("aes_sched: TMO must be at least 1");
  end

  state_t        state;
  logic [N-1:0]  arb_req;
  logic [N-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          advance;
  logic          used_core;
  logic [WW-1:0] wd;

  // Requests are only visible to the arbiter while idle and out of reset,
  // so a grant is exactly a completed request handshake.
  assign arb_req   = (state == IDLE && !reset) ? req_valid : '0;
  assign advance   = |grant;
  assign req_ready = grant;

  rr_arbiter #(.N(N)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (advance),
    .grant   (grant),
    .idx     (gidx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      used_core  <= 1'b0;
      wd         <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      core_ce    <= 1'b0;
      core_key   <= '0;
      core_msg   <= '0;
      core_dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (advance) begin
            core_key <= req_key[gidx];
            core_msg <= req_msg[gidx];
            core_dir <= req_dir[gidx];
            resp_id  <= gidx;
            if (dir_supported(INV, req_dir[gidx])) begin
              used_core <= 1'b1;
              core_ce   <= 1'b1;
              wd        <= '0;
              state     <= RUN;
            end else begin
              // Rejected without touching the core; no GAP needed afterwards.
              used_core  <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              state      <= RESP;
            end
          end
        end
        RUN: begin
          // done is tested first so it wins over a coincident timeout.
          if (core_done) begin
            resp_data  <= core_data;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            core_ce    <= 1'b0;
            state      <= RESP;
          end else if (wd == WW'(TMO - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            core_ce    <= 1'b0;
            state      <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= used_core ? GAP : IDLE;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// Directed self-checking bench for aes_sched: main instance (INV=2) with a
// behavioural core model, plus an encrypt-only instance (INV=0).
module tb_aes_sched;

  localparam int unsigned N = 4;
  localparam int unsigned K = 128;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY3 = 128'h000000000000000000000000000000ff;
  localparam logic [127:0] MSG3 = 128'h0123456789abcdeffedcba9876543210;
  // MSG3 ^ KEY3 ^ all-ones (decrypt in the core model)
  localparam logic [127:0] RES3 = 128'hfedcba98765432100123456789abcd10;
  localparam logic [127:0] KEY1 = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]        req_valid, req_ready, req_dir;
  logic [N-1:0][K-1:0] req_key;
  logic [N-1:0][127:0] req_msg;
  logic                resp_valid, resp_ready, resp_err;
  logic [1:0]          resp_id;
  logic [127:0]        resp_data;
  logic                core_ce, core_dir, core_done;
  logic [K-1:0]        core_key;
  logic [127:0]        core_msg, core_data;

  logic [N-1:0]        req_valid_e, req_ready_e;
  logic                resp_valid_e, resp_err_e, core_ce_e, core_dir_e;
  logic [1:0]          resp_id_e;
  logic [127:0]        resp_data_e, core_msg_e;
  logic [K-1:0]        core_key_e;
  logic                core_done_e = 1'b0;
  logic [127:0]        core_data_e = '0;

  int   lat = 11;
  int   ce_cnt = 0;
  logic ce_e_seen = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  aes_sched #(.K(K), .INV(2), .N(N), .TMO(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_msg(req_msg), .req_dir(req_dir),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_ce(core_ce), .core_key(core_key), .core_msg(core_msg), .core_dir(core_dir),
    .core_done(core_done), .core_data(core_data)
  );

  aes_sched #(.K(K), .INV(0), .N(N), .TMO(64)) dut_e (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_e), .req_ready(req_ready_e),
    .req_key(req_key), .req_msg(req_msg), .req_dir(req_dir),
    .resp_valid(resp_valid_e), .resp_ready(resp_ready), .resp_id(resp_id_e),
    .resp_data(resp_data_e), .resp_err(resp_err_e),
    .core_ce(core_ce_e), .core_key(core_key_e), .core_msg(core_msg_e), .core_dir(core_dir_e),
    .core_done(core_done_e), .core_data(core_data_e)
  );

  always #5 clk = ~clk;

  // Core model: done after `lat` enabled cycles (lat=0: never).
  always @(posedge clk) ce_cnt <= core_ce ? ce_cnt + 1 : 0;
  always @(posedge clk) if (core_ce_e) ce_e_seen <= 1'b1;
  assign core_done = core_ce && (lat != 0) && (ce_cnt == lat - 1);
  always_comb begin
    core_data = core_msg ^ core_key ^ {128{core_dir}};
    if (core_key == KEY0 && core_msg == MSG0 && !core_dir) core_data = RES0;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on the first RUN negedge; returns on the negedge resp_valid is seen.
  task automatic wait_resp(input string tag, output int ce_n);
    ce_n = 0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid) break;
      if (core_ce) ce_n++;
      @(negedge clk);
    end
    check(tag, 256'(resp_valid), 256'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, got, bad;
    int order[5];
    req_valid = '0; req_dir = '0; req_key = '0; req_msg = '0;
    req_valid_e = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 256'({req_ready, resp_valid, resp_id, resp_err, core_ce, core_dir}), 256'(0));
    check("rst_data", 256'(resp_data), 256'(0));
    check("rst_core", {core_key, core_msg}, 256'(0));
    reset = 1'b0;

    // Single encrypt job with the known AES-128 vector
    req_key[0] = KEY0; req_msg[0] = MSG0; req_dir[0] = 1'b0; req_valid[0] = 1'b1;
    #1 check("t1_grant", 256'(req_ready), 256'(4'b0001));
    @(negedge clk); req_valid = '0;
    check("t1_ce_on", 256'(core_ce), 256'(1));
    check("t1_core_in", {core_key, core_msg}, {KEY0, MSG0});
    wait_resp("t1_resp", n);
    check("t1_ce_len", 256'(n), 256'(11));
    check("t1_id", 256'(resp_id), 256'(0));
    check("t1_data", 256'(resp_data), 256'(RES0));
    check("t1_err", 256'(resp_err), 256'(0));
    @(negedge clk);
    check("t1_gap", 256'({core_ce, resp_valid}), 256'(0));
    req_valid[1] = 1'b1;
    #1 check("t1_gap_noready", 256'(req_ready), 256'(0));
    @(negedge clk);
    #1 check("t1_idle_ready", 256'(req_ready), 256'(4'b0010));
    req_valid = '0;

    // Fairness from a fresh pointer
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    lat = 2; req_valid = '1; got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        order[got] = $clog2(req_ready);
        got++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    check("fair_count", 256'(got), 256'(5));
    for (int i = 0; i < 5; i++) check($sformatf("fair_%0d", i), 256'(order[i]), 256'(i % 4));
    wait_resp("fair_drain", n);
    repeat (2) @(negedge clk);

    // Backpressure on a decrypt job from requester 3
    resp_ready = 1'b0; lat = 3;
    req_key[3] = KEY3; req_msg[3] = MSG3; req_dir[3] = 1'b1; req_valid[3] = 1'b1;
    #1 check("bp_grant", 256'(req_ready), 256'(4'b1000));
    @(negedge clk); req_valid = '0;
    wait_resp("bp_resp", n);
    check("bp_ce_len", 256'(n), 256'(3));
    check("bp_id", 256'(resp_id), 256'(3));
    check("bp_data", 256'(resp_data), 256'(RES3));
    req_valid = '1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!resp_valid || resp_id != 2'd3 || resp_data != RES3 || resp_err || core_ce || req_ready != '0)
        bad++;
      @(negedge clk);
    end
    check("bp_hold", 256'(bad), 256'(0));
    resp_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    check("bp_released", 256'(resp_valid), 256'(0));
    @(negedge clk);

    // Unsupported direction on the encrypt-only instance
    req_dir[2] = 1'b1; req_valid_e[2] = 1'b1;
    #1 check("rej_grant", 256'(req_ready_e), 256'(4'b0100));
    @(negedge clk); req_valid_e = '0;
    check("rej_valid", 256'(resp_valid_e), 256'(1));
    check("rej_id", 256'(resp_id_e), 256'(2));
    check("rej_data", 256'(resp_data_e), 256'(0));
    check("rej_err", 256'(resp_err_e), 256'(1));
    @(negedge clk);
    check("rej_done", 256'(resp_valid_e), 256'(0));
    req_valid_e[2] = 1'b1;
    #1 check("rej_no_gap", 256'(req_ready_e), 256'(4'b0100));
    req_valid_e = '0;
    check("rej_no_ce", 256'(ce_e_seen), 256'(0));
    req_dir[2] = 1'b0;

    // Timeout with no done
    lat = 0; req_key[1] = KEY1; req_msg[1] = '0; req_dir[1] = 1'b0; req_valid[1] = 1'b1;
    #1 check("to_grant", 256'(req_ready), 256'(4'b0010));
    @(negedge clk); req_valid = '0;
    wait_resp("to_resp", n);
    check("to_ce_len", 256'(n), 256'(64));
    check("to_err", 256'(resp_err), 256'(1));
    check("to_data", 256'(resp_data), 256'(0));
    check("to_id", 256'(resp_id), 256'(1));
    repeat (2) @(negedge clk);

    // done in the same cycle as the timeout
    lat = 64; req_valid[1] = 1'b1;
    #1 check("tod_grant", 256'(req_ready), 256'(4'b0010));
    @(negedge clk); req_valid = '0;
    wait_resp("tod_resp", n);
    check("tod_ce_len", 256'(n), 256'(64));
    check("tod_err", 256'(resp_err), 256'(0));
    check("tod_data", 256'(resp_data), 256'(KEY1));
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN
    lat = 0; req_key[2] = KEY3; req_msg[2] = MSG3; req_valid[2] = 1'b1;
    #1 check("rr_grant", 256'(req_ready), 256'(4'b0100));
    @(negedge clk); req_valid = '0;
    repeat (5) @(negedge clk);
    check("rr_in_run", 256'(core_ce), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    check("rr_ctrl", 256'({req_ready, resp_valid, resp_id, resp_err, core_ce, core_dir}), 256'(0));
    check("rr_data", 256'(resp_data), 256'(0));
    check("rr_core", {core_key, core_msg}, 256'(0));
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid || core_ce) bad++;
    end
    check("rr_no_stale", 256'(bad), 256'(0));
    req_valid = '1;
    #1 check("rr_ptr", 256'(req_ready), 256'(4'b0001));
    req_valid = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
